bf_addsub_stage: RTL and testbench

//  Butterfly add/sub stage directly downstream of the dual-mode multiply-reduce unit.

---
 rtl/bf_addsub_stage.sv | 177 +++++++++++++++++
 tb/tb_bf_addsub_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_addsub_stage.sv
// ---------------------------------------------------------------------------
// bf_addsub_stage
//   Butterfly add/sub stage that sits directly after the dual-mode
//   multiply-reduce unit. Operand u is delayed MUL_LAT cycles so it meets the
//   reduced product v. Each beat produces (u+v) mod q and (u-v) mod q,
//   optionally multiplied by 2^-1 mod q (inverse-NTT butterflies).
//
//   mode = 0 : Kyber, q = 3329, two independent 12-bit lanes packed {hi,lo}
//   mode = 1 : Dilithium, q = 8380417, one 23-bit coefficient in [22:0]
//
//   Latency in_valid -> out_valid is MUL_LAT + 2 cycles, full throughput.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous clear of every in-flight valid bit
//   in_valid   u/mode/halve valid; matching multiplier input issued same cycle
//   u          upper operand (Kyber {hi,lo}, Dilithium {1'b0,u[22:0]})
//   mode       0 = Kyber lanes, 1 = Dilithium
//   halve      1 = multiply both results by 2^-1 mod q
//   v          reduced product, presented MUL_LAT cycles after its in_valid
//   out_valid  out_sum / out_diff carry a new result
//   out_sum    (u+v) mod q, optionally halved; same packing as u
//   out_diff   (u-v) mod q, optionally halved; same packing as u
//   busy       any valid beat in the delay line or output pipeline
// ---------------------------------------------------------------------------
module bf_addsub_stage #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [23:0] u,
  input  logic        mode,
  input  logic        halve,
  input  logic [23:0] v,
  output logic        out_valid,
  output logic [23:0] out_sum,
  output logic [23:0] out_diff,
  output logic        busy
);

  localparam logic [12:0] KQ = 13'd3329;
  localparam logic [23:0] DQ = 24'd8380417;

  // One beat travelling alongside the multiplier.
  typedef struct packed {
    logic        valid;
    logic        mode;
    logic        halve;
    logic [23:0] u;
  } beat_t;

  beat_t dl_q [MUL_LAT];

  // Stage A: raw sum / offset difference. Kyber packs {hi[12:0], lo[12:0]};
  // Dilithium uses [23:0] with the top two bits zero.
  logic        a_valid;
  logic        a_mode;
  logic        a_halve;
  logic [25:0] a_s;
  logic [25:0] a_d;

  // -------------------------------------------------------------------------
  // Stage B helpers: conditional subtract, then optional halving mod q.
  // For odd x, (x+q) is even and (x+q)/2 == x * 2^-1 mod q.
  // -------------------------------------------------------------------------
  function automatic logic [11:0] kyber_fix(input logic [12:0] x, input logic h);
    logic [12:0] r;
    logic [12:0] y;
    r = (x >= KQ) ? x - KQ : x;
    y = r;
    if (h) y = r[0] ? (r + KQ) >> 1 : r >> 1;
    return y[11:0];
  endfunction

  function automatic logic [22:0] dil_fix(input logic [23:0] x, input logic h);
    logic [23:0] r;
    logic [23:0] y;
    r = (x >= DQ) ? x - DQ : x;
    y = r;
    if (h) y = r[0] ? (r + DQ) >> 1 : r >> 1;
    return y[22:0];
  endfunction

  // -------------------------------------------------------------------------
  // Delay line: u, mode and halve ride along with the multiplier latency.
  // -------------------------------------------------------------------------
  // NOTE: the delay line is ordinary flops, not a RAM, so it is safe and cheap
  // to reset every entry; that is what lets busy be exact right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) dl_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the loop order below does not matter.
      dl_q[0] <= '{valid: in_valid & ~flush, mode: mode, halve: halve, u: u};
      for (int i = 1; i < MUL_LAT; i++) begin
        dl_q[i]       <= dl_q[i-1];
        dl_q[i].valid <= dl_q[i-1].valid & ~flush;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage A: combine the tapped operand with v. The difference is offset by
  // q so it never goes negative; 13 bits per Kyber lane and 24 bits for
  // Dilithium hold up to 2q-2 without overflow.
  // -------------------------------------------------------------------------
  beat_t       tap;
  logic [12:0] ks_hi, ks_lo, kd_hi, kd_lo;
  logic [23:0] ds, dd;

  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally), so no latch is inferred.
  always_comb begin
    tap   = dl_q[MUL_LAT-1];
    ks_lo = {1'b0, tap.u[11:0]}  + {1'b0, v[11:0]};
    ks_hi = {1'b0, tap.u[23:12]} + {1'b0, v[23:12]};
    kd_lo = {1'b0, tap.u[11:0]}  - {1'b0, v[11:0]}  + KQ;
    kd_hi = {1'b0, tap.u[23:12]} - {1'b0, v[23:12]} + KQ;
    ds    = {1'b0, tap.u[22:0]}  + {1'b0, v[22:0]};
    dd    = {1'b0, tap.u[22:0]}  - {1'b0, v[22:0]}  + DQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_mode  <= 1'b0;
      a_halve <= 1'b0;
      a_s     <= '0;
      a_d     <= '0;
    end else begin
      a_valid <= tap.valid & ~flush;
      if (tap.valid) begin
        a_mode  <= tap.mode;
        a_halve <= tap.halve;
        a_s     <= tap.mode ? {2'b00, ds} : {ks_hi, ks_lo};
        a_d     <= tap.mode ? {2'b00, dd} : {kd_hi, kd_lo};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage B: reduce into [0,q), optionally halve, register outputs. Data
  // registers only load on a valid beat, so results hold between beats.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_diff  <= '0;
    end else begin
      out_valid <= a_valid & ~flush;
      if (a_valid) begin
        if (a_mode) begin
          out_sum  <= {1'b0, dil_fix(a_s[23:0], a_halve)};
          out_diff <= {1'b0, dil_fix(a_d[23:0], a_halve)};
        end else begin
          out_sum  <= {kyber_fix(a_s[25:13], a_halve), kyber_fix(a_s[12:0], a_halve)};
          out_diff <= {kyber_fix(a_d[25:13], a_halve), kyber_fix(a_d[12:0], a_halve)};
        end
      end
    end
  end

  // busy covers the whole path up to and including the presented result.
  logic dl_busy;
  always_comb begin
    dl_busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) dl_busy = dl_busy | dl_q[i].valid;
  end

  assign busy = dl_busy | a_valid | out_valid;

endmodule

// File: tb/tb_bf_addsub_stage.sv
// ---------------------------------------------------------------------------
// tb_bf_addsub_stage
//   Scoreboard bench: each issued beat pushes its expected result (computed
//   with plain modular arithmetic) and its expected output cycle; a monitor
//   pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_bf_addsub_stage;

  localparam int     MUL_LAT = 3;
  localparam longint KYQ     = 3329;
  localparam longint DLQ     = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] u = '0;
  logic        mode = 1'b0;
  logic        halve = 1'b0;
  logic [23:0] v = '0;
  logic        out_valid;
  logic [23:0] out_sum;
  logic [23:0] out_diff;
  logic        busy;

  bf_addsub_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .u         (u),
    .mode      (mode),
    .halve     (halve),
    .v         (v),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] s;
    logic [23:0] d;
    int          due;
  } exp_t;

  exp_t        exp_q [$];
  logic [23:0] v_sched [int];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: modular arithmetic straight from the definition.
  function automatic longint ref_lane(input longint q, input longint a, input longint b,
                                      input bit sub, input bit h);
    longint r;
    r = sub ? (a - b + q) % q : (a + b) % q;
    if (h) r = (r * ((q + 1) / 2)) % q;
    return r;
  endfunction

  function automatic logic [23:0] ref_val(input bit m, input bit h, input bit sub,
                                          input logic [23:0] a, input logic [23:0] b);
    longint hi, lo, d;
    logic [23:0] res;
    if (m) begin
      d   = ref_lane(DLQ, longint'(a[22:0]), longint'(b[22:0]), sub, h);
      res = 24'(d);
    end else begin
      hi  = ref_lane(KYQ, longint'(a[23:12]), longint'(b[23:12]), sub, h);
      lo  = ref_lane(KYQ, longint'(a[11:0]),  longint'(b[11:0]),  sub, h);
      res = (24'(hi) << 12) | 24'(lo);
    end
    return res;
  endfunction

  // v is presented exactly MUL_LAT edges after the beat's accepting edge;
  // otherwise it carries random junk.
  always @(negedge clk) begin
    if (v_sched.exists(cyc + 1)) v = v_sched[cyc + 1];
    else v = 24'($urandom);
  end

  // Monitor.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.s));
        check("out_diff", 32'(out_diff), 32'(e.d));
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // Issue one beat at the current negedge; returns one cycle later.
  task automatic send(input bit m, input bit h, input logic [23:0] uu, input logic [23:0] vv);
    exp_t e;
    in_valid = 1'b1;
    mode     = m;
    halve    = h;
    u        = uu;
    v_sched[cyc + 1 + MUL_LAT] = vv;
    if (!flush) begin
      e.s   = ref_val(m, h, 1'b0, uu, vv);
      e.d   = ref_val(m, h, 1'b1, uu, vv);
      e.due = cyc + MUL_LAT + 2;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rand_operands(input bit m, output logic [23:0] a, output logic [23:0] b);
    if (m) begin
      a = 24'($urandom_range(0, 8380416));
      b = 24'($urandom_range(0, 8380416));
    end else begin
      a = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
      b = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    check("busy_idle_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [23:0] a, b;
    bit          m;

    // Reset state.
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum", 32'(out_sum), 32'd0);
    check("reset_out_diff", 32'(out_diff), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors.
    send(1'b0, 1'b0, {12'd3000, 12'd5}, {12'd500, 12'd10});
    check("busy_after_accept", 32'(busy), 32'd1);
    drain();
    send(1'b1, 1'b0, 24'd8380416, 24'd1);
    send(1'b0, 1'b1, {12'd1, 12'd1}, {12'd0, 12'd0});
    send(1'b1, 1'b1, 24'd0, 24'd1);
    send(1'b0, 1'b0, {12'd3328, 12'd0}, {12'd3328, 12'd3328});
    send(1'b1, 1'b1, 24'd8380416, 24'd8380416);
    drain();

    // 8 back-to-back beats alternating mode and halve.
    for (int i = 0; i < 8; i++) begin
      m = i[0];
      rand_operands(m, a, b);
      send(m, i[1], a, b);
    end
    drain();

    // Random beats with random gaps.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      rand_operands(m, a, b);
      send(m, 1'($urandom), a, b);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    drain();

    // Flush with three beats in flight plus one dropped beat.
    for (int i = 0; i < 3; i++) begin
      rand_operands(1'b0, a, b);
      send(1'b0, 1'b0, a, b);
    end
    exp_q.delete();
    flush = 1'b1;
    rand_operands(1'b1, a, b);
    send(1'b1, 1'b0, a, b);
    flush = 1'b0;
    check("busy_after_flush", 32'(busy), 32'd0);
    check("out_valid_after_flush", 32'(out_valid), 32'd0);
    quiet(8, "no_out_valid_after_flush");
    rand_operands(1'b1, a, b);
    send(1'b1, 1'b1, a, b);
    drain();

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      rand_operands(1'b1, a, b);
      send(1'b1, 1'b0, a, b);
    end
    #2 rst = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_sum", 32'(out_sum), 32'd0);
    check("midreset_out_diff", 32'(out_diff), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    quiet(8, "no_out_valid_after_reset");
    send(1'b0, 1'b1, {12'd3328, 12'd7}, {12'd2, 12'd3328});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
